// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and data-memory port of the MEM-stage access unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [15:0] d_addr;
    logic        d_we;
    logic [15:0] d_wdata;
    logic [15:0] d_dataout;
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, d_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall, d_addr, d_we, d_wdata
    );
    modport master (
        output req_valid, req_we, req_addr, req_wdata, d_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall, d_addr, d_we, d_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator sequencing one load/store at a time onto the data memory port
module mem_access_unit #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 16
) (
    input logic              clk,
    input logic              r_st,
    mem_access_unit_if.slave bus
);
    // ERR spends the same cycle an ACCESS would, so errors respond with store latency
    typedef enum logic [2:0] {IDLE, ERR, ACCESS, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d, stall_q, stall_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic        d_we_q, d_we_d;
    logic [15:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic        accept, oor, capture;
    assign accept  = bus.req_valid & (state_q == IDLE);
    assign oor     = 32'(bus.req_addr) >= MEM_DEPTH;
    assign capture = (state_q == ACCESS & ~we_q & WAIT_CYCLES == 0) | (state_q == WAIT & cnt_q == 4'd1);
    always_ff @(posedge clk) begin
        if (!r_st) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            stall_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            d_we_q      <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            stall_q     <= stall_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            d_we_q      <= d_we_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.req_valid ? (oor ? ERR : ACCESS) : IDLE;
            ERR:     state_d = RESP;
            ACCESS:  state_d = (we_q || WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
        we_d  = accept ? bus.req_we : we_q;
        cnt_d = (state_q == ACCESS) ? 4'(WAIT_CYCLES) : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    end
    always_comb begin
        ready_d     = state_d == IDLE;
        stall_d     = state_d != IDLE;
        rsp_valid_d = state_d == RESP;
        rsp_err_d   = state_q == ERR;
        d_we_d      = accept & ~oor & bus.req_we;
        d_addr_d    = (accept & ~oor) ? bus.req_addr : d_addr_q;
        d_wdata_d   = d_we_d ? bus.req_wdata : d_wdata_q;
        rsp_rdata_d = capture ? bus.d_dataout : rsp_rdata_q;
    end
    assign bus.req_ready = ready_q;
    assign bus.stall     = stall_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.d_we      = d_we_q;
    assign bus.d_addr    = d_addr_q;
    assign bus.d_wdata   = d_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench; u0 runs WAIT_CYCLES=1, u1 runs WAIT_CYCLES=4 for the mid-load reset
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic r_st0, r_st1;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    mem_access_unit_if b0();
    mem_access_unit_if b1();
    mem_access_unit #(.WAIT_CYCLES(1), .MEM_DEPTH(16)) u0 (.clk(clk), .r_st(r_st0), .bus(b0));
    mem_access_unit #(.WAIT_CYCLES(4), .MEM_DEPTH(16)) u1 (.clk(clk), .r_st(r_st1), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    always @(posedge clk)
        if (!r_st0) for (int i = 0; i < 16; i++) mem0[i] <= (i == 1) ? 16'hffff : (i == 3) ? 16'haaaa : 16'(i * 257);
        else if (b0.d_we) mem0[b0.d_addr[3:0]] <= b0.d_wdata;
    always @(posedge clk)
        if (!r_st1) for (int i = 0; i < 16; i++) mem1[i] <= (i == 1) ? 16'hffff : (i == 3) ? 16'haaaa : 16'(i * 257);
        else if (b1.d_we) mem1[b1.d_addr[3:0]] <= b1.d_wdata;
    assign b0.d_dataout = mem0[b0.d_addr[3:0]];
    assign b1.d_dataout = mem1[b1.d_addr[3:0]];

    typedef struct {logic err; logic [15:0] rdata; int due;} exp_t;
    exp_t        sb[$];
    int          acc_q[$];
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response is queued at the accept edge; latency counted from that edge
    always @(posedge clk)
        if (r_st0 && b0.req_valid && b0.req_ready) begin
            sb.push_back('{exp_err, exp_rdata, cyc + exp_lat});
            acc_q.push_back(cyc);
        end

    always @(negedge clk)
        if (r_st0 && b0.rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", 32'(b0.rsp_err), 32'(e.err));
                chk("rsp_rdata", 32'(b0.rsp_rdata), 32'(e.rdata));
                chk("rsp_cycle", cyc, e.due);
            end
        end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic err, input logic [15:0] rdata, input int lat);
        int t;
        exp_err = err; exp_rdata = rdata; exp_lat = lat;
        b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata; b0.req_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!b0.stall && t < 20);
        b0.req_valid = 1'b0;
        chk("accept", 32'(t < 20), 32'd1);
        chk("d_we_access", 32'(b0.d_we), 32'(we & ~err));
        if (!err) chk("d_addr_access", 32'(b0.d_addr), 32'(addr));
        @(negedge clk);
        chk("d_we_after", 32'(b0.d_we), 32'd0);
        t = 0;
        while ((sb.size() != 0 || b0.stall) && t < 40) begin @(negedge clk); t++; end
        chk("rsp_wait", 32'(t < 40), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, n0, we_cnt, idle_cnt, e, rsp_cnt;
        r_st0 = 1'b0; r_st1 = 1'b0;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
        exp_err = 1'b0; exp_rdata = '0; exp_lat = 0;
        repeat (2) @(negedge clk);
        r_st0 = 1'b1; r_st1 = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(b0.req_ready), 32'd1);
        chk("rst_stall", 32'(b0.stall), 32'd0);
        chk("rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
        chk("rst_d_we", 32'(b0.d_we), 32'd0);
        chk("rst_d_addr", 32'(b0.d_addr), 32'd0);
        chk("rst_rdata", 32'(b0.rsp_rdata), 32'd0);
        issue(1'b1, 16'd4, 16'h3bff, 1'b0, 16'h0000, 2);
        issue(1'b0, 16'd4, 16'h0000, 1'b0, 16'h3bff, 3);
        issue(1'b0, 16'd1, 16'h0000, 1'b0, 16'hffff, 3);
        issue(1'b0, 16'd3, 16'h0000, 1'b0, 16'haaaa, 3);
        issue(1'b0, 16'd16, 16'h0000, 1'b1, 16'haaaa, 2);
        issue(1'b1, 16'hffff, 16'h1111, 1'b1, 16'haaaa, 2);
        chk("err_no_write", 32'(mem0[15]), 32'(16'd15 * 16'd257));
        issue(1'b1, 16'd15, 16'h5a5a, 1'b0, 16'haaaa, 2);
        issue(1'b0, 16'd15, 16'h0000, 1'b0, 16'h5a5a, 3);
        // Back-to-back stores with req_valid held high
        n0 = acc_q.size();
        exp_err = 1'b0; exp_rdata = 16'h5a5a; exp_lat = 2;
        b0.req_we = 1'b1; b0.req_addr = 16'd7; b0.req_wdata = 16'h1234; b0.req_valid = 1'b1;
        we_cnt = 0; idle_cnt = 0; t = 0;
        while (acc_q.size() < n0 + 3 && t < 30) begin
            @(negedge clk); t++;
            we_cnt += int'(b0.d_we);
            if (acc_q.size() > n0 && acc_q.size() < n0 + 3 && !b0.stall) idle_cnt++;
        end
        b0.req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_q.size() - n0), 32'd3);
        if (acc_q.size() >= n0 + 3) begin
            chk("b2b_gap1", acc_q[n0 + 1] - acc_q[n0], 32'd3);
            chk("b2b_gap2", acc_q[n0 + 2] - acc_q[n0 + 1], 32'd3);
        end
        repeat (4) begin @(negedge clk); we_cnt += int'(b0.d_we); end
        chk("b2b_we_pulses", we_cnt, 32'd3);
        chk("b2b_idle_cycles", idle_cnt, 32'd2);
        issue(1'b0, 16'd7, 16'h0000, 1'b0, 16'h1234, 3);
        // u1: full load first, then abandon a load in WAIT via reset
        b1.req_we = 1'b0; b1.req_addr = 16'd3; b1.req_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!b1.stall && t < 20);
        b1.req_valid = 1'b0;
        e = cyc; t = 0;
        while (!b1.rsp_valid && t < 20) begin @(negedge clk); t++; end
        chk("u1_latency", cyc - e, 32'(2 + 4 - 1));
        chk("u1_rdata", 32'(b1.rsp_rdata), 32'haaaa);
        @(negedge clk);
        b1.req_addr = 16'd1; b1.req_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!b1.stall && t < 20);
        b1.req_valid = 1'b0;
        @(negedge clk);
        r_st1 = 1'b0;
        @(negedge clk);
        chk("u1_rst_ready", 32'(b1.req_ready), 32'd1);
        chk("u1_rst_stall", 32'(b1.stall), 32'd0);
        chk("u1_rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("u1_rst_rdata", 32'(b1.rsp_rdata), 32'd0);
        r_st1 = 1'b1;
        rsp_cnt = 0;
        repeat (12) begin @(negedge clk); rsp_cnt += int'(b1.rsp_valid); end
        chk("u1_no_rsp", rsp_cnt, 32'd0);
        chk("u1_rdata_held", 32'(b1.rsp_rdata), 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
